// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide/remainder, one operation in flight.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_dz
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;
    localparam logic [3:0] OP_REM = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_z;
    logic             r_c;
    logic             r_n;
    logic             r_dz;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH:0]   r_acc;
    logic [3:0]       r_op;

    logic                    w_accept;
    logic                    w_multi;
    logic                    w_last;
    logic [SHW-1:0]          w_sh;
    logic [WIDTH:0]          w_sum;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0]        w_res;
    logic                    w_c;
    logic                    w_def;

    logic [WIDTH-1:0] w_mul_sum;
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH:0]   w_diff;
    logic             w_rge;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_fin;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign flag_n    = r_n;
    assign flag_dz   = r_dz;

    assign w_accept = in_valid & in_ready;
    assign w_multi  = (sel == OP_MUL) | (sel == OP_DIV) | (sel == OP_REM);
    assign w_last   = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_multi ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_next = w_multi ? S_BUSY : S_DONE;
                end else if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Single-cycle result, evaluated straight from the input operands.
    always_comb begin
        w_sh  = in_b[SHW-1:0];
        w_sum = {1'b0, in_a} + {1'b0, in_b};
        w_a_s = in_a;
        w_sra = w_a_s >>> w_sh;
        w_res = '0;
        w_c   = 1'b0;
        w_def = 1'b1;
        case (sel)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = in_a - in_b;
                w_c   = (in_a < in_b);
            end
            OP_AND: w_res = in_a & in_b;
            OP_OR:  w_res = in_a | in_b;
            OP_XOR: w_res = in_a ^ in_b;
            OP_SHL: w_res = in_a << w_sh;
            OP_SHR: w_res = in_a >> w_sh;
            OP_CMP: begin
                if (in_a == in_b) begin
                    w_res = WIDTH'(0);
                end else if (in_a > in_b) begin
                    w_res = WIDTH'(1);
                end else begin
                    w_res = WIDTH'(2);
                end
            end
            OP_SRA: w_res = w_sra;
            default: w_def = 1'b0;
        endcase
    end

    // One iteration step: shift-add multiply, or one restoring-divide quotient bit.
    always_comb begin
        w_mul_sum = r_acc[WIDTH-1:0] + (r_opb[0] ? r_opa : '0);
        w_rsh     = {r_acc[WIDTH-1:0], r_opa[WIDTH-1]};
        w_rge     = (w_rsh >= {1'b0, r_opb});
        w_diff    = w_rsh - {1'b0, r_opb};
        w_quo     = {r_opa[WIDTH-2:0], w_rge};
        case (r_op)
            OP_MUL:  w_fin = w_mul_sum;
            OP_DIV:  w_fin = w_quo;
            default: w_fin = w_rge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_out <= '0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            r_n   <= 1'b0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (!w_multi) begin
                r_out <= w_res;
                r_z   <= w_def & (w_res == '0);
                r_c   <= w_c;
                r_n   <= w_def & w_res[WIDTH-1];
                r_dz  <= 1'b0;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + SHW'(1);
            if (w_last) begin
                r_out <= w_fin;
                r_z   <= (w_fin == '0);
                r_c   <= 1'b0;
                r_n   <= w_fin[WIDTH-1];
                r_dz  <= (r_op != OP_MUL) & (r_opb == '0);
            end
        end
    end

    // Operand/iteration registers: only meaningful while BUSY, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_opa <= in_a;
            r_opb <= in_b;
            r_op  <= sel;
            r_acc <= '0;
        end else if (r_state == S_BUSY) begin
            if (r_op == OP_MUL) begin
                r_acc <= {1'b0, w_mul_sum};
                r_opa <= r_opa << 1;
                r_opb <= r_opb >> 1;
            end else begin
                r_acc <= w_rge ? w_diff : w_rsh;
                r_opa <= w_quo;
            end
        end
    end

endmodule
